// File: rtl/regfile_writeback_buffer.sv
// Writeback FIFO in front of the register file write port, with youngest-first
// forwarding of pending writes to the three read-address queries.
module regfile_writeback_buffer #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 5,
  parameter  int DW    = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          rf_hold,
  output logic          rf_enable,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_data,
  input  logic [AW-1:0] qa_addr,
  input  logic [AW-1:0] qb_addr,
  input  logic [AW-1:0] qd_addr,
  output logic          fa_hit,
  output logic          fb_hit,
  output logic          fd_hit,
  output logic [DW-1:0] fa_data,
  output logic [DW-1:0] fb_data,
  output logic [DW-1:0] fd_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [AW-1:0] r_mem_addr [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_rf_enable;
  logic [AW-1:0] r_rf_addr;
  logic [DW-1:0] r_rf_data;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_q     [3];
  logic          w_hit   [3];
  logic [DW-1:0] w_fdata [3];

  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign in_ready = !full;
  assign count    = r_count;
  assign w_push   = in_valid && !full;
  assign w_pop    = !empty && !rf_hold;

  assign rf_enable = r_rf_enable;
  assign rf_addr   = r_rf_addr;
  assign rf_data   = r_rf_data;

  // Queue storage: payload is never reset, only the occupancy state is.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= in_addr;
      r_mem_data[r_wptr] <= in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_wptr == PW'(i)))
          r_vld[i] <= 1'b1;
        else if (w_pop && (r_rptr == PW'(i)))
          r_vld[i] <= 1'b0;
      end
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  // Write-port stage: one enable pulse per drained entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rf_enable <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_data   <= '0;
    end else begin
      r_rf_enable <= w_pop;
      if (w_pop) begin
        r_rf_addr <= r_mem_addr[r_rptr];
        r_rf_data <= r_mem_data[r_rptr];
      end
    end
  end

  assign w_q[0] = qa_addr;
  assign w_q[1] = qb_addr;
  assign w_q[2] = qd_addr;

  // Walk oldest to youngest starting at the read pointer so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    for (int p = 0; p < 3; p++) begin
      w_hit[p]   = r_rf_enable && (r_rf_addr == w_q[p]);
      w_fdata[p] = w_hit[p] ? r_rf_data : '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = r_rptr + PW'(k);
        if (r_vld[idx] && (r_mem_addr[idx] == w_q[p])) begin
          w_hit[p]   = 1'b1;
          w_fdata[p] = r_mem_data[idx];
        end
      end
    end
  end

  assign fa_hit  = w_hit[0];
  assign fb_hit  = w_hit[1];
  assign fd_hit  = w_hit[2];
  assign fa_data = w_fdata[0];
  assign fb_data = w_fdata[1];
  assign fd_data = w_fdata[2];

endmodule

// File: tb/tb_regfile_writeback_buffer.sv
// Directed bench for regfile_writeback_buffer with hand-computed expectations.
module tb_regfile_writeback_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          rf_hold = 1'b0;
  logic          rf_enable;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [AW-1:0] qa_addr = '0;
  logic [AW-1:0] qb_addr = '0;
  logic [AW-1:0] qd_addr = '0;
  logic          fa_hit, fb_hit, fd_hit;
  logic [DW-1:0] fa_data, fb_data, fd_data;
  logic [CW-1:0] count;
  logic          empty, full;

  int n_cmp = 0;
  int n_err = 0;

  regfile_writeback_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .rf_hold(rf_hold), .rf_enable(rf_enable), .rf_addr(rf_addr), .rf_data(rf_data),
    .qa_addr(qa_addr), .qb_addr(qb_addr), .qd_addr(qd_addr),
    .fa_hit(fa_hit), .fb_hit(fb_hit), .fd_hit(fd_hit),
    .fa_data(fa_data), .fb_data(fb_data), .fd_data(fd_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Power-on reset
    #2 reset = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_rf_enable", rf_enable, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_fa_hit", fa_hit, 0);
    chk("rst_fa_data", fa_data, 0);
    reset = 1'b0;
    tick();

    // Single write, latency
    push(5'd3, 32'h14);
    chk("single_count_after_push", count, 1);
    chk("single_no_enable_same_edge", rf_enable, 0);
    tick();
    chk("single_enable", rf_enable, 1);
    chk("single_addr", rf_addr, 3);
    chk("single_data", rf_data, 32'h14);
    chk("single_count_drained", count, 0);
    tick();
    chk("single_enable_drop", rf_enable, 0);
    chk("single_addr_hold", rf_addr, 3);
    chk("single_empty", empty, 1);

    // Fill while held, reject 5th
    rf_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(AW'(i), DW'(32'h14 + i));
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, 4);
    in_valid = 1'b1;
    in_addr  = 5'd9;
    in_data  = 32'h99;
    tick();
    tick();
    chk("fill_fifth_rejected", count, 4);
    chk("fill_no_enable_held", rf_enable, 0);
    in_valid = 1'b0;
    rf_hold  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_enable", rf_enable, 1);
      chk("drain_addr", rf_addr, i);
      chk("drain_data", rf_data, 32'h14 + i);
    end
    tick();
    chk("drain_enable_end", rf_enable, 0);
    chk("drain_empty", empty, 1);

    // Forwarding priority
    rf_hold = 1'b1;
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
    qa_addr = 5'd7;
    qb_addr = 5'd8;
    #1;
    chk("fwd_a_hit", fa_hit, 1);
    chk("fwd_a_young", fa_data, 32'hB);
    chk("fwd_b_miss_hit", fb_hit, 0);
    chk("fwd_b_miss_data", fb_data, 0);
    rf_hold = 1'b0;
    tick();
    rf_hold = 1'b1;
    #1;
    chk("fwd_inflight_enable", rf_enable, 1);
    chk("fwd_inflight_data", rf_data, 32'hA);
    chk("fwd_queue_beats_inflight", fa_data, 32'hB);
    chk("fwd_count1", count, 1);
    rf_hold = 1'b0;
    tick();
    chk("fwd_inflight_only_hit", fa_hit, 1);
    chk("fwd_inflight_only_data", fa_data, 32'hB);
    tick();
    chk("fwd_none_hit", fa_hit, 0);
    chk("fwd_none_data", fa_data, 0);

    // Steady push+pop at count=2 across pointer wrap
    rf_hold = 1'b1;
    push(5'd10, 32'h100);
    push(5'd11, 32'h101);
    rf_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_addr  = AW'(12 + i);
      in_data  = DW'(32'h102 + i);
      tick();
      chk("stream_count", count, 2);
      chk("stream_enable", rf_enable, 1);
      chk("stream_addr", rf_addr, 10 + i);
      chk("stream_data", rf_data, 32'h100 + i);
    end
    in_valid = 1'b0;
    for (int i = 10; i < 12; i++) begin
      tick();
      chk("stream_tail_addr", rf_addr, 10 + i);
      chk("stream_tail_data", rf_data, 32'h100 + i);
    end
    tick();
    chk("stream_done_enable", rf_enable, 0);
    chk("stream_done_empty", empty, 1);

    // Address boundaries 31 and 0
    rf_hold = 1'b1;
    push(5'd31, 32'hDEAD);
    push(5'd0, 32'hBEEF);
    qd_addr = 5'd31;
    #1;
    chk("bnd_q31_hit", fd_hit, 1);
    chk("bnd_q31_data", fd_data, 32'hDEAD);
    qd_addr = 5'd0;
    #1;
    chk("bnd_q0_hit", fd_hit, 1);
    chk("bnd_q0_data", fd_data, 32'hBEEF);
    rf_hold = 1'b0;
    tick();
    chk("bnd_issue31", rf_addr, 31);
    chk("bnd_issue31_data", rf_data, 32'hDEAD);
    tick();
    chk("bnd_issue0", rf_addr, 0);
    chk("bnd_issue0_en", rf_enable, 1);
    chk("bnd_issue0_data", rf_data, 32'hBEEF);
    tick();

    // Reset mid-operation
    rf_hold = 1'b1;
    push(5'd5, 32'h55);
    push(5'd6, 32'h66);
    rf_hold = 1'b0;
    qa_addr = 5'd5;
    tick();
    chk("midrst_pre_enable", rf_enable, 1);
    reset = 1'b1;
    #1;
    chk("midrst_enable_async", rf_enable, 0);
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_fa_hit", fa_hit, 0);
    chk("midrst_fa_data", fa_data, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst_no_enable", rf_enable, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
